// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, SPART window addresses and FSM state encoding
package mem_port_arbiter_pkg;
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 32;
    localparam logic [27:0] SPART_DATA_ADDR = 28'h8000000;
    localparam logic [27:0] SPART_STAT_ADDR = 28'h8000001;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RELEASE = 2'd2} state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way winner select, round-robin on ties unless fixed priority
module rr_pick2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);
    assign grant = (valid0 && valid1) ? ((FIXED_PRIO != 0) ? 1'b0 : !last_grant) : valid1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory command port between two requesters, with release cycle and timeout
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TIMEOUT    = 1024,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    input  logic              r0_rw,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data_wr,
    output logic [DATA_W-1:0] r0_data_rd,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic              r1_rw,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data_wr,
    output logic [DATA_W-1:0] r1_data_rd,
    output logic              r1_ready,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_wr,
    input  logic [DATA_W-1:0] mem_data_rd,
    input  logic              mem_ready,
    output logic              timeout_err,
    output logic              busy
);
    state_t state, state_nx;
    logic win, sel, last_grant, done, expire;
    logic [31:0] timer;

    rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .valid0(r0_valid),
        .valid1(r1_valid),
        .last_grant(last_grant),
        .grant(win)
    );

    // a mem_ready on the expiry cycle wins over the timeout
    assign done   = state == ISSUE && mem_ready;
    assign expire = state == ISSUE && !mem_ready && TIMEOUT != 0 && timer == 32'(TIMEOUT - 1);
    assign busy   = state != IDLE;

    always_comb begin
        state_nx = state == IDLE  ? ((r0_valid || r1_valid) ? ISSUE : IDLE) :
                   state == ISSUE ? ((done || expire) ? RELEASE : ISSUE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= 1'b0;
            last_grant  <= 1'b1;
            timer       <= '0;
            mem_valid   <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_data_wr <= '0;
            r0_data_rd  <= '0;
            r1_data_rd  <= '0;
            r0_ready    <= 1'b0;
            r1_ready    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r0_ready    <= 1'b0;
            r1_ready    <= 1'b0;
            timeout_err <= 1'b0;
            if (state == IDLE && (r0_valid || r1_valid)) begin
                sel         <= win;
                mem_valid   <= 1'b1;
                mem_rw      <= win ? r1_rw : r0_rw;
                mem_addr    <= win ? r1_addr : r0_addr;
                mem_data_wr <= win ? r1_data_wr : r0_data_wr;
                timer       <= '0;
            end
            if (state == ISSUE) timer <= timer + 32'd1;
            if (done || expire) begin
                mem_valid   <= 1'b0;
                timeout_err <= expire;
                if (sel) begin
                    r1_data_rd <= done ? mem_data_rd : '1;
                    r1_ready   <= 1'b1;
                end else begin
                    r0_data_rd <= done ? mem_data_rd : '1;
                    r0_ready   <= 1'b1;
                end
                if (done) last_grant <= sel;
            end
        end
    end
endmodule
